hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Parametrised pipeline hazard controller for the MIPS pipeline, sitting beside the IF/ID register and driving the PC, IF/ID and ID/EX control muxes. It detects load-use dependencies for any number of source operands and inserts a configurable number of stall cycles. It flushes wrong-path instructions after a taken branch for a configurable number of cycles, and freezes the whole pipeline while data memory is busy. Multi-cycle stalls and flushes are tracked by a small registered state machine with a down-counter.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands checked per ID instruction
- LOAD_LAT, 1, stall cycles per load-use hazard (>=1)
- BR_FLUSH, 1, flush cycles per taken branch (>=1)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_src_addr  in  NUM_SRC*REG_AW  ID-stage source register addresses; operand i at bits [i*REG_AW +: REG_AW]
- id_src_valid  in  NUM_SRC  operand i is actually read
- ex_memread  in  1  ID/EX holds a load
- ex_regwrite  in  1  ID/EX instruction writes a register
- ex_rd  in  REG_AW  ID/EX destination register
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- br_taken  in  1  branch resolved taken in EX this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- id_ex_bubble  out  1  force ID/EX control to NOP
- if_id_flush  out  1  clear IF/ID to NOP
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB
- stall_cycles  out  32  perf counter (HAZ_PERF_EN only)
- flush_cycles  out  32  perf counter (HAZ_PERF_EN only)

## Operation
- States: RUN, LOAD_STALL, FLUSH. Down-counter cnt has width $clog2(max(LOAD_LAT,BR_FLUSH)+1).
- Hazard match: ex_memread & ex_regwrite & ex_rd != 0 & any i with id_src_valid[i] and id_src_addr[i] == ex_rd. Register 0 never matches.
- Outputs are Mealy: a function of the registered state plus the current inputs. Default (run) values are pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pipe_hold=0.
- Priority, highest first: rst > mem_busy > br_taken > load-use / LOAD_STALL > run.
- mem_busy:
  - pipe_hold=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - State and cnt are frozen.
  - br_taken is ignored; EX is frozen, so br_taken is re-presented after busy drops.
- br_taken, in any state:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
  - Next state is FLUSH with cnt=BR_FLUSH-1 if BR_FLUSH>1, else RUN.
  - Branch cancels any pending load stall.
- FLUSH with cnt>0: if_id_flush=1, id_ex_bubble=1, pc/if_id write enabled. cnt decrements; move to RUN when cnt reaches 1.
- Load-use hit in RUN:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Next state is LOAD_STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1, else RUN (the hazard is re-evaluated next cycle).
- LOAD_STALL: same stall outputs. cnt decrements; move to RUN when cnt reaches 1.

## Timing
- During rst and the cycle after: state=RUN, cnt=0, all outputs at run values, perf counters 0.
- Load-use stall is asserted in the same cycle the dependency is visible: zero latency.
- Total stall per hazard is exactly LOAD_LAT cycles, plus any mem_busy cycles that occur during it.
- Total flush per taken branch is exactly BR_FLUSH cycles, plus any mem_busy cycles that occur during it.
- rst mid-stall or mid-flush aborts the sequence on the next edge.
- br_taken together with a load-use hit: the branch wins and no stall is counted.

## Configuration
- HAZ_PERF_EN defined:
  - stall_cycles increments on each load-stall cycle; flush_cycles increments on each flush cycle.
  - Counters exclude mem_busy cycles, saturate at 2^32-1 and clear on rst.
- HAZ_PERF_EN undefined: both ports and all counter logic are absent.

## Structure
- Shared package hazard_pkg holds the state enum (RUN, LOAD_STALL, FLUSH) and the run-value output constants.
- One sub-module: hazard_src_match, a parametrised comparator that reduces NUM_SRC operand matches to a single hit.

## Test plan
- ex_memread=1, ex_rd=5, src0=5 valid, LOAD_LAT=1 -> one cycle with pc_write=0, id_ex_bubble=1, then run values.
- LOAD_LAT=3, src1=7 matches ex_rd=7 -> exactly 3 stall cycles; stall_cycles=3.
- ex_rd=0 matching src0=0, or a match with id_src_valid=0 -> no stall.
- BR_FLUSH=2, br_taken pulse -> 2 cycles if_id_flush=1 with pc_write=1; flush_cycles=2.
- mem_busy held 4 cycles during cycle 2 of LOAD_LAT=3 stall -> pipe_hold=1 for 4 cycles, then 2 more stall cycles.
- br_taken together with a load-use hit, then rst asserted mid-FLUSH -> flush wins with no stall, and outputs return to run values after the reset edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with the HAZ_PERF_EN macro.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } haz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pipe_hold;
  } haz_ctrl_t;

  // Control bundles for each pipeline action; CTRL_RUN is the idle value.
  localparam haz_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_bubble: 1'b0, if_id_flush: 1'b0, pipe_hold: 1'b0};
  localparam haz_ctrl_t CTRL_HOLD  = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b0, if_id_flush: 1'b0, pipe_hold: 1'b1};
  localparam haz_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_bubble: 1'b1, if_id_flush: 1'b1, pipe_hold: 1'b0};
  localparam haz_ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_bubble: 1'b1, if_id_flush: 1'b0, pipe_hold: 1'b0};

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Reduces per-operand comparisons against the EX destination to one hazard hit.
// Register 0 is hard-wired and never produces a hit.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         rd,
  input  logic                      enable,
  output logic                      hit
);

  logic [NUM_SRC-1:0] match_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign match_s[i] = src_valid[i] && (src_addr[i*REG_AW +: REG_AW] == rd);
  end

  assign hit = enable && (rd != {REG_AW{1'b0}}) && (|match_s);

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch flush and memory-busy freeze controller for the MIPS pipeline.
// Define HAZ_PERF_EN to add the stall_cycles / flush_cycles performance counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic                      ex_memread,
  input  logic                      ex_regwrite,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      mem_busy,
  input  logic                      br_taken,
  output logic                      pc_write,
  output logic                      if_id_write,
  output logic                      id_ex_bubble,
  output logic                      if_id_flush,
  output logic                      pipe_hold
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               flush_cycles
`endif
);

  localparam int CNT_MAX = max_of(LOAD_LAT, BR_FLUSH);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  haz_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  haz_ctrl_t        ctrl_s;
  logic             hit_s;

  hazard_src_match #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC)
  ) u_src_match (
    .src_addr  (id_src_addr),
    .src_valid (id_src_valid),
    .rd        (ex_rd),
    .enable    (ex_memread & ex_regwrite),
    .hit       (hit_s)
  );

  // Mealy next-state and control decode; cnt holds the remaining extra cycles.
  always_comb begin
    ctrl_s       = CTRL_RUN;
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (rst) begin
      ctrl_s       = CTRL_RUN;
      state_next_s = RUN;
      cnt_next_s   = {CNT_W{1'b0}};
    end else if (mem_busy) begin
      ctrl_s = CTRL_HOLD;
    end else if (br_taken) begin
      ctrl_s = CTRL_FLUSH;
      if (BR_FLUSH > 1) begin
        state_next_s = FLUSH;
        cnt_next_s   = CNT_W'(BR_FLUSH - 1);
      end else begin
        state_next_s = RUN;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    end else begin
      case (state_r)
        FLUSH: begin
          ctrl_s       = CTRL_FLUSH;
          cnt_next_s   = cnt_r - CNT_W'(1);
          state_next_s = (cnt_r <= CNT_W'(1)) ? RUN : FLUSH;
        end
        LOAD_STALL: begin
          ctrl_s       = CTRL_STALL;
          cnt_next_s   = cnt_r - CNT_W'(1);
          state_next_s = (cnt_r <= CNT_W'(1)) ? RUN : LOAD_STALL;
        end
        RUN: begin
          if (hit_s) begin
            ctrl_s = CTRL_STALL;
            if (LOAD_LAT > 1) begin
              state_next_s = LOAD_STALL;
              cnt_next_s   = CNT_W'(LOAD_LAT - 1);
            end else begin
              state_next_s = RUN;
              cnt_next_s   = {CNT_W{1'b0}};
            end
          end else begin
            ctrl_s = CTRL_RUN;
          end
        end
        default: begin
          ctrl_s       = CTRL_RUN;
          state_next_s = RUN;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  assign pc_write     = ctrl_s.pc_write;
  assign if_id_write  = ctrl_s.if_id_write;
  assign id_ex_bubble = ctrl_s.id_ex_bubble;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign pipe_hold    = ctrl_s.pipe_hold;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Saturating perf counters; hold cycles decode to neither stall nor flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (ctrl_s.id_ex_bubble && !ctrl_s.if_id_flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ctrl_s.if_id_flush && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_cycles = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: two controller configurations against a cycle-budget reference model.
module tb_hazard_control_unit;

  localparam int K_RUN = 0, K_HOLD = 1, K_FLUSH = 2, K_STALL = 3;
  localparam int LL[2] = '{3, 1};
  localparam int BF[2] = '{2, 1};
  localparam int NS[2] = '{3, 2};

  typedef struct {
    bit        rst, busy, br, memread, regwrite;
    bit [4:0]  rd;
    bit [14:0] addr;
    bit [2:0]  valid;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst, ex_memread, ex_regwrite, mem_busy, br_taken;
  logic [4:0]  ex_rd;
  logic [14:0] id_src_addr;
  logic [2:0]  id_src_valid;
  logic        pcw_a, ifw_a, bub_a, fl_a, hold_a;
  logic        pcw_b, ifw_b, bub_b, fl_b, hold_b;
`ifdef HAZ_PERF_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  longint      exp_sc[2], exp_fc[2];
`endif

  int stall_left[2], flush_left[2];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_AW(5), .NUM_SRC(3), .LOAD_LAT(3), .BR_FLUSH(2)) dut_a (
    .clk(clk), .rst(rst), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_busy(mem_busy), .br_taken(br_taken),
    .pc_write(pcw_a), .if_id_write(ifw_a), .id_ex_bubble(bub_a), .if_id_flush(fl_a), .pipe_hold(hold_a)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc_a), .flush_cycles(fc_a)
`endif
  );

  hazard_control_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .BR_FLUSH(1)) dut_b (
    .clk(clk), .rst(rst), .id_src_addr(id_src_addr[9:0]), .id_src_valid(id_src_valid[1:0]),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_busy(mem_busy), .br_taken(br_taken),
    .pc_write(pcw_b), .if_id_write(ifw_b), .id_ex_bubble(bub_b), .if_id_flush(fl_b), .pipe_hold(hold_b)
`ifdef HAZ_PERF_EN
    , .stall_cycles(sc_b), .flush_cycles(fc_b)
`endif
  );

  // ---------------- reference model ----------------
  function automatic bit model_hit(int d);
    if (!(ex_memread && ex_regwrite) || ex_rd == 5'd0) return 1'b0;
    for (int i = 0; i < NS[d]; i++)
      if (id_src_valid[i] && id_src_addr[i*5 +: 5] == ex_rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int classify(int d);
    if (rst)               return K_RUN;
    if (mem_busy)          return K_HOLD;
    if (br_taken)          return K_FLUSH;
    if (flush_left[d] > 0) return K_FLUSH;
    if (stall_left[d] > 0 || model_hit(d)) return K_STALL;
    return K_RUN;
  endfunction

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold}
  function automatic logic [4:0] exp_ctrl(int d);
    case (classify(d))
      K_HOLD:  return 5'b00001;
      K_FLUSH: return 5'b11110;
      K_STALL: return 5'b00100;
      default: return 5'b11000;
    endcase
  endfunction

  function automatic logic [4:0] act_ctrl(int d);
    if (d == 0) return {pcw_a, ifw_a, bub_a, fl_a, hold_a};
    return {pcw_b, ifw_b, bub_b, fl_b, hold_b};
  endfunction

`ifdef HAZ_PERF_EN
  function automatic longint act_sc(int d);
    return (d == 0) ? longint'(sc_a) : longint'(sc_b);
  endfunction
  function automatic longint act_fc(int d);
    return (d == 0) ? longint'(fc_a) : longint'(fc_b);
  endfunction
`endif

  function automatic void model_update(int d);
    int k;
    k = classify(d);
    if (rst) begin
      stall_left[d] = 0;
      flush_left[d] = 0;
`ifdef HAZ_PERF_EN
      exp_sc[d] = 0;
      exp_fc[d] = 0;
`endif
    end else if (k == K_FLUSH) begin
      if (br_taken) begin
        flush_left[d] = BF[d] - 1;
        stall_left[d] = 0;
      end else begin
        flush_left[d]--;
      end
`ifdef HAZ_PERF_EN
      exp_fc[d]++;
`endif
    end else if (k == K_STALL) begin
      if (stall_left[d] > 0) stall_left[d]--;
      else stall_left[d] = LL[d] - 1;
`ifdef HAZ_PERF_EN
      exp_sc[d]++;
`endif
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.busy = 1'b0; s.br = 1'b0; s.memread = 1'b0;
    s.regwrite = 1'($urandom_range(0, 1));
    s.rd = 5'($urandom);
    s.addr = 15'($urandom);
    s.valid = 3'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; mem_busy = s.busy; br_taken = s.br;
    ex_memread = s.memread; ex_regwrite = s.regwrite; ex_rd = s.rd;
    id_src_addr = s.addr; id_src_valid = s.valid;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t s;
    s = idle(); s.rst = 1'b1; s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd4;
    s.addr[4:0] = 5'd4; s.valid = 3'b001; s.br = 1'b1;
    apply(s);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) apply(idle());
      #1;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (act_ctrl(d) !== 5'b11000) begin
          n_fail++;
          $display("FAIL reset dut%0d step%0d ctrl got %b exp %b", d, i, act_ctrl(d), 5'b11000);
        end
`ifdef HAZ_PERF_EN
        n_tests++;
        if (act_sc(d) !== 64'd0 || act_fc(d) !== 64'd0) begin
          n_fail++;
          $display("FAIL reset_perf dut%0d got %0d/%0d exp 0/0", d, act_sc(d), act_fc(d));
        end
`endif
      end
      tick();
    end
  endtask

  task automatic run_table(input string name, input stim_t q[$]);
    foreach (q[i]) begin
      apply(q[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (act_ctrl(d) !== exp_ctrl(d)) begin
          n_fail++;
          $display("FAIL %s dut%0d step%0d ctrl got %b exp %b", name, d, i, act_ctrl(d), exp_ctrl(d));
        end
`ifdef HAZ_PERF_EN
        n_tests++;
        if (act_sc(d) !== exp_sc[d] || act_fc(d) !== exp_fc[d]) begin
          n_fail++;
          $display("FAIL %s_perf dut%0d step%0d got %0d/%0d exp %0d/%0d", name, d, i,
                   act_sc(d), act_fc(d), exp_sc[d], exp_fc[d]);
        end
`endif
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    stim_t s;
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd5;
    s.addr[4:0] = 5'd5; s.valid = 3'b001;
    q.push_back(s);
    // Zero-latency stall must be visible in the hazard cycle itself.
    apply(s);
    #1;
    n_tests++;
    if (pcw_b !== 1'b0 || bub_b !== 1'b1 || pcw_a !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_zero_lat got pcw_a=%b pcw_b=%b bub_b=%b exp 0 0 1", pcw_a, pcw_b, bub_b);
    end
    repeat (4) q.push_back(idle());
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd7;
    s.addr[9:5] = 5'd7; s.addr[4:0] = 5'd3; s.addr[14:10] = 5'd2; s.valid = 3'b010;
    q.push_back(s);
    repeat (5) q.push_back(idle());
    // Third operand only exists on the wide configuration.
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd9;
    s.addr = {5'd9, 5'd1, 5'd2}; s.valid = 3'b111;
    q.push_back(s);
    repeat (4) q.push_back(idle());
    run_table("load_use", q);
  endtask

  task automatic test_no_match();
    stim_t q[$];
    stim_t s;
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd0;
    s.addr = 15'd0; s.valid = 3'b111;
    q.push_back(s);
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd6;
    s.addr = {5'd6, 5'd6, 5'd6}; s.valid = 3'b000;
    q.push_back(s);
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b0; s.rd = 5'd6;
    s.addr = {5'd6, 5'd6, 5'd6}; s.valid = 3'b111;
    q.push_back(s);
    run_table("no_match", q);
  endtask

  task automatic test_branch();
    stim_t q[$];
    stim_t s;
    s = idle(); s.br = 1'b1;
    q.push_back(s);
    repeat (3) q.push_back(idle());
    q.push_back(s);
    q.push_back(s);
    repeat (3) q.push_back(idle());
    run_table("branch", q);
  endtask

  task automatic test_mem_busy();
    stim_t q[$];
    stim_t s;
    s = idle(); s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd11;
    s.addr[4:0] = 5'd11; s.valid = 3'b001;
    q.push_back(s);
    repeat (4) begin
      s = idle(); s.busy = 1'b1; s.br = 1'($urandom_range(0, 1));
      q.push_back(s);
    end
    repeat (4) q.push_back(idle());
    run_table("mem_busy", q);
  endtask

  task automatic test_branch_hit_rst();
    stim_t q[$];
    stim_t s;
    s = idle(); s.br = 1'b1; s.memread = 1'b1; s.regwrite = 1'b1; s.rd = 5'd12;
    s.addr[4:0] = 5'd12; s.valid = 3'b001;
    q.push_back(s);
    s = idle(); s.rst = 1'b1;
    q.push_back(s);
    repeat (3) q.push_back(idle());
    run_table("br_hit_rst", q);
  endtask

  task automatic test_random();
    stim_t q[$];
    stim_t s;
    for (int i = 0; i < 500; i++) begin
      s.rst      = ($urandom_range(0, 99) < 2);
      s.busy     = ($urandom_range(0, 99) < 15);
      s.br       = ($urandom_range(0, 99) < 10);
      s.memread  = ($urandom_range(0, 99) < 50);
      s.regwrite = ($urandom_range(0, 99) < 85);
      s.rd       = 5'($urandom_range(0, 3));
      s.addr     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      s.valid    = 3'($urandom);
      q.push_back(s);
    end
    run_table("random", q);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_match();
    test_branch();
    test_mem_busy();
    test_branch_hit_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
